sw_event_arbiter: RTL

//   Turns N already-debounced switch levels into a serial stream of press events.

---
 rtl/sw_event_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/sw_event_arbiter.sv
// Converts debounced switch levels into a serial stream of press events.
// Rising edges set per-switch pending flags; a round-robin arbiter moves them into a show-ahead FIFO.
module sw_event_arbiter #(
  parameter int NUM_SW     = 4,
  parameter int IDX_W      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_SW-1:0] SW_db,
  output logic              EVT_valid,
  output logic [IDX_W-1:0]  EVT_id,
  input  logic              EVT_ready,
  output logic [NUM_SW-1:0] PEND,
  output logic              OVF
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              armed_q;
  logic [NUM_SW-1:0] prev_q;
  logic [NUM_SW-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  mem_q [FIFO_DEPTH];

  logic [NUM_SW-1:0] rise;
  logic [NUM_SW-1:0] grant_mask;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  idx;
  logic              found;
  logic              pop;
  logic              grant;

  // NOTE: every variable assigned in always_comb gets a default before any branch, so no latch is inferred.
  always_comb begin
    rise  = armed_q ? (SW_db & ~prev_q) : '0;
    pop   = (count_q != '0) & EVT_ready;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    // Scan forward from the round-robin pointer, wrapping past the last switch.
    for (int k = 0; k < NUM_SW; k++) begin
      idx = IDX_W'((int'(rr_q) + k) % NUM_SW);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    grant = found & ((count_q != CNT_W'(FIFO_DEPTH)) | pop);

    grant_mask = '0;
    if (grant) grant_mask[win] = 1'b1;

    // A rise on the switch being granted re-arms its flag instead of counting as a merge.
    pend_d = (pend_q & ~grant_mask) | rise;
    ovf_d  = ovf_q | (|(rise & pend_q & ~grant_mask));

    rr_d = rr_q;
    if (grant) rr_d = (int'(win) == NUM_SW - 1) ? '0 : IDX_W'(win + 1'b1);

    count_d = count_q;
    case ({grant, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      armed_q  <= 1'b0;
      prev_q   <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      armed_q <= 1'b1;
      prev_q  <= SW_db;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      rr_q    <= rr_d;
      count_q <= count_d;
      if (grant) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which entries are meaningful.
  always_ff @(posedge CLK) begin
    if (grant) mem_q[wr_ptr_q] <= win;
  end

  assign EVT_valid = (count_q != '0);
  assign EVT_id    = EVT_valid ? mem_q[rd_ptr_q] : '0;
  assign PEND      = pend_q;
  assign OVF       = ovf_q;

endmodule
